// File: rtl/vmmul_pkg.sv
// Shared definitions for the parametrised matrix-multiply accelerator:
// FSM encoding, accumulator width helper and memory element stride.
package vmmul_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    COMPUTE = 3'd3,
    STORE   = 3'd4,
    DONE    = 3'd5
  } state_e;

  localparam int unsigned ELEM_STRIDE = 4;

  // Full-precision accumulator width: product width plus growth over DIM terms.
  function automatic int accw(input int dw, input int dim);
    return 2 * dw + $clog2(dim);
  endfunction

endpackage

// File: rtl/vmmul_mac.sv
// Multiply-accumulate lane with signed/unsigned operands and a
// combinational saturate-or-truncate view of the running sum.
module vmmul_mac
  import vmmul_pkg::*;
#(
  parameter int DIM = 4,
  parameter int DW  = 16,
  parameter int OW  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic          signed_mode,
  input  logic          sat_mode,
  input  logic [DW-1:0] op_a,
  input  logic [DW-1:0] op_b,
  output logic [31:0]   result
);

  localparam int ACCW = accw(DW, DIM);
  localparam int EW   = ((ACCW > 32) ? ACCW : 32) + 1;

  logic [ACCW-1:0] acc_r;
  logic [ACCW-1:0] ax_s;
  logic [ACCW-1:0] bx_s;
  logic [ACCW-1:0] prod_s;
  logic [ACCW-1:0] acc_next_s;

  // Range-check in a widened domain so the clamp decision never overflows.
  function automatic logic [31:0] convert(input logic [ACCW-1:0] acc, input logic sgn, input logic sat);
    logic [EW-1:0] ext;
    logic [OW-1:0] val;
    logic          in_range;
    ext = sgn ? {{(EW-ACCW){acc[ACCW-1]}}, acc} : {{(EW-ACCW){1'b0}}, acc};
    if (sgn) begin
      in_range = (ext[EW-1:OW-1] == {(EW-OW+1){ext[EW-1]}});
    end else begin
      in_range = (ext[EW-1:OW] == {(EW-OW){1'b0}});
    end
    if (!sat || in_range) begin
      val = ext[OW-1:0];
    end else if (sgn) begin
      val = ext[EW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    end else begin
      val = {OW{1'b1}};
    end
    return sgn ? 32'(signed'(val)) : 32'(val);
  endfunction

  // Operand extension, product and next accumulator value.
  always_comb begin
    ax_s       = signed_mode ? {{(ACCW-DW){op_a[DW-1]}}, op_a} : {{(ACCW-DW){1'b0}}, op_a};
    bx_s       = signed_mode ? {{(ACCW-DW){op_b[DW-1]}}, op_b} : {{(ACCW-DW){1'b0}}, op_b};
    prod_s     = ax_s * bx_s;
    acc_next_s = (clr ? {ACCW{1'b0}} : acc_r) + prod_s;
    result     = convert(acc_next_s, signed_mode, sat_mode);
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r <= {ACCW{1'b0}};
    end else if (en) begin
      acc_r <= acc_next_s;
    end else begin
      acc_r <= acc_r;
    end
  end

endmodule

// File: rtl/vmmul_gen.sv
// MMIO-launched C = A x B engine: fetches A and B element by element, runs
// one MAC per cycle in i,j,k order, then streams C back to memory.
module vmmul_gen
  import vmmul_pkg::*;
#(
  parameter int DIM = 4,
  parameter int DW  = 16,
  parameter int OW  = 32,
  parameter int AW  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode_signed,
  input  logic          mode_sat,
  input  logic [AW-1:0] a_base,
  input  logic [AW-1:0] b_base,
  input  logic [AW-1:0] c_base,
  output logic          busy,
  output logic          done,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [AW-1:0] rd_addr,
  input  logic          rsp_valid,
  input  logic [31:0]   rsp_data,
  output logic          wr_valid,
  input  logic          wr_ready,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic [31:0]   perf_cycles
);

  localparam int N  = DIM * DIM;
  localparam int NW = $clog2(N);
  localparam int IW = $clog2(DIM);
  localparam logic [NW-1:0] CNT_LAST = NW'(N - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIM - 1);
  localparam logic [AW-1:0] STRIDE   = AW'(ELEM_STRIDE);

  state_e          state_r, state_s;
  logic            busy_s, done_s;
  logic            busy_r, done_r;
  logic            rd_valid_r, wr_valid_r, outstanding_r;
  logic [AW-1:0]   rd_addr_r, wr_addr_r, next_rd_addr_s;
  logic [31:0]     wr_data_r, perf_r;
  logic [AW-1:0]   a_base_r, b_base_r, c_base_r;
  logic            sgn_r, sat_r;
  logic [NW-1:0]   cnt_r;
  logic [IW-1:0]   i_r, j_r, k_r;
  logic [NW-1:0]   a_idx_s, b_idx_s, c_idx_s;
  logic            rsp_fire_s, wr_fire_s, cnt_last_s, mac_last_s;
  logic [31:0]     mac_result_s;
  logic [31:0]     rsp_unused_s;
  logic [DW-1:0]   a_buf_r [N];
  logic [DW-1:0]   b_buf_r [N];
  logic [31:0]     c_buf_r [N];

  assign rsp_unused_s = rsp_data;

  // Handshake events and buffer indexing.
  always_comb begin
    rsp_fire_s = rsp_valid & outstanding_r;
    wr_fire_s  = wr_valid_r & wr_ready;
    cnt_last_s = (cnt_r == CNT_LAST);
    mac_last_s = (i_r == IDX_LAST) && (j_r == IDX_LAST) && (k_r == IDX_LAST);
    a_idx_s    = NW'(i_r) * NW'(DIM) + NW'(k_r);
    b_idx_s    = NW'(k_r) * NW'(DIM) + NW'(j_r);
    c_idx_s    = NW'(i_r) * NW'(DIM) + NW'(j_r);
    if (state_r == LOAD_A && cnt_last_s) begin
      next_rd_addr_s = b_base_r;
    end else begin
      next_rd_addr_s = rd_addr_r + STRIDE;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (start) state_s = LOAD_A; else state_s = IDLE;
      LOAD_A:  if (rsp_fire_s && cnt_last_s) state_s = LOAD_B; else state_s = LOAD_A;
      LOAD_B:  if (rsp_fire_s && cnt_last_s) state_s = COMPUTE; else state_s = LOAD_B;
      COMPUTE: if (mac_last_s) state_s = STORE; else state_s = COMPUTE;
      STORE:   if (wr_fire_s && cnt_last_s) state_s = DONE; else state_s = STORE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM outputs, registered one cycle later.
  always_comb begin
    busy_s = (state_s != IDLE);
    done_s = (state_s == DONE);
  end

  // Control registers, counters and memory port drivers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      rd_valid_r    <= 1'b0;
      wr_valid_r    <= 1'b0;
      outstanding_r <= 1'b0;
      rd_addr_r     <= {AW{1'b0}};
      wr_addr_r     <= {AW{1'b0}};
      wr_data_r     <= 32'd0;
      perf_r        <= 32'd0;
      a_base_r      <= {AW{1'b0}};
      b_base_r      <= {AW{1'b0}};
      c_base_r      <= {AW{1'b0}};
      sgn_r         <= 1'b0;
      sat_r         <= 1'b0;
      cnt_r         <= {NW{1'b0}};
      i_r           <= {IW{1'b0}};
      j_r           <= {IW{1'b0}};
      k_r           <= {IW{1'b0}};
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
      if (state_r == IDLE && start) begin
        perf_r <= 32'd0;
      end else if (busy_r) begin
        perf_r <= perf_r + 32'd1;
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            a_base_r      <= a_base;
            b_base_r      <= b_base;
            c_base_r      <= c_base;
            sgn_r         <= mode_signed;
            sat_r         <= mode_sat;
            rd_valid_r    <= 1'b1;
            rd_addr_r     <= a_base;
            outstanding_r <= 1'b0;
            cnt_r         <= {NW{1'b0}};
            i_r           <= {IW{1'b0}};
            j_r           <= {IW{1'b0}};
            k_r           <= {IW{1'b0}};
          end
        end
        LOAD_A, LOAD_B: begin
          if (rd_valid_r && rd_ready) begin
            rd_valid_r    <= 1'b0;
            outstanding_r <= 1'b1;
          end
          // Next request goes out only after the previous response returns.
          if (rsp_fire_s) begin
            outstanding_r <= 1'b0;
            cnt_r         <= cnt_last_s ? {NW{1'b0}} : cnt_r + NW'(1);
            rd_valid_r    <= !(state_r == LOAD_B && cnt_last_s);
            rd_addr_r     <= next_rd_addr_s;
          end
        end
        COMPUTE: begin
          if (k_r == IDX_LAST) begin
            k_r <= {IW{1'b0}};
            if (j_r == IDX_LAST) begin
              j_r <= {IW{1'b0}};
              i_r <= (i_r == IDX_LAST) ? {IW{1'b0}} : i_r + IW'(1);
            end else begin
              j_r <= j_r + IW'(1);
            end
          end else begin
            k_r <= k_r + IW'(1);
          end
        end
        STORE: begin
          if (!wr_valid_r) begin
            wr_valid_r <= 1'b1;
            wr_addr_r  <= c_base_r;
            wr_data_r  <= c_buf_r[cnt_r];
          end else if (wr_ready) begin
            if (cnt_last_s) begin
              wr_valid_r <= 1'b0;
              cnt_r      <= {NW{1'b0}};
            end else begin
              cnt_r     <= cnt_r + NW'(1);
              wr_addr_r <= wr_addr_r + STRIDE;
              wr_data_r <= c_buf_r[cnt_r + NW'(1)];
            end
          end
        end
        DONE: begin
          wr_valid_r <= 1'b0;
        end
        default: begin
          rd_valid_r <= 1'b0;
          wr_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Operand and result buffers; left untouched by reset.
  always_ff @(posedge clk) begin
    if (!rst && rsp_fire_s && state_r == LOAD_A) begin
      a_buf_r[cnt_r] <= rsp_data[DW-1:0];
    end
    if (!rst && rsp_fire_s && state_r == LOAD_B) begin
      b_buf_r[cnt_r] <= rsp_data[DW-1:0];
    end
    if (!rst && state_r == COMPUTE && k_r == IDX_LAST) begin
      c_buf_r[c_idx_s] <= mac_result_s;
    end
  end

  vmmul_mac #(
    .DIM (DIM),
    .DW  (DW),
    .OW  (OW)
  ) u_mac (
    .clk         (clk),
    .rst         (rst),
    .en          (state_r == COMPUTE),
    .clr         (k_r == {IW{1'b0}}),
    .signed_mode (sgn_r),
    .sat_mode    (sat_r),
    .op_a        (a_buf_r[a_idx_s]),
    .op_b        (b_buf_r[b_idx_s]),
    .result      (mac_result_s)
  );

  assign busy        = busy_r;
  assign done        = done_r;
  assign rd_valid    = rd_valid_r;
  assign rd_addr     = rd_addr_r;
  assign wr_valid    = wr_valid_r;
  assign wr_addr     = wr_addr_r;
  assign wr_data     = wr_data_r;
  assign perf_cycles = perf_r;

endmodule
